// File: rtl/lcd_bus_pkg.sv
// Shared command codes and receiver FSM encoding for the 8080-style LCD bus receiver.
package lcd_bus_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CASET0   = 4'd1,
        ST_CASET1   = 4'd2,
        ST_CASET2   = 4'd3,
        ST_CASET3   = 4'd4,
        ST_PASET0   = 4'd5,
        ST_PASET1   = 4'd6,
        ST_PASET2   = 4'd7,
        ST_PASET3   = 4'd8,
        ST_RAMWR_HI = 4'd9,
        ST_RAMWR_LO = 4'd10
    } rx_state_e;

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for the asynchronous LCD bus plus a registered lcd_wr rising-edge detector.
// Data, D/C and RD ride through the same stages as WR so every byte event sees its own data.
module lcd_bus_sync (
    input  logic       clk_100,
    input  logic       reset,
    input  logic [7:0] lcd_db,
    input  logic       lcd_wr,
    input  logic       lcd_d_c,
    input  logic       lcd_rd,
    input  logic       lcd_reset,
    output logic       byte_ev,
    output logic [7:0] byte_db,
    output logic       byte_dc,
    output logic       byte_rd,
    output logic       panel_rst_n
);

    // Bit map: {lcd_reset, lcd_rd, lcd_d_c, lcd_wr, lcd_db[7:0]}
    logic [11:0] meta_r;
    logic [11:0] sync_r;
    logic        wr_prev_r;
    logic        byte_ev_r;
    logic [7:0]  byte_db_r;
    logic        byte_dc_r;
    logic        byte_rd_r;

    // Synchronizer stages followed by the edge-detect register stage
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            meta_r    <= 12'd0;
            sync_r    <= 12'd0;
            wr_prev_r <= 1'b0;
            byte_ev_r <= 1'b0;
            byte_db_r <= 8'd0;
            byte_dc_r <= 1'b0;
            byte_rd_r <= 1'b0;
        end else begin
            meta_r    <= {lcd_reset, lcd_rd, lcd_d_c, lcd_wr, lcd_db};
            sync_r    <= meta_r;
            wr_prev_r <= sync_r[8];
            byte_ev_r <= sync_r[8] & ~wr_prev_r;
            byte_db_r <= sync_r[7:0];
            byte_dc_r <= sync_r[9];
            byte_rd_r <= sync_r[10];
        end
    end

    assign byte_ev     = byte_ev_r;
    assign byte_db     = byte_db_r;
    assign byte_dc     = byte_dc_r;
    assign byte_rd     = byte_rd_r;
    assign panel_rst_n = sync_r[11];

endmodule

// File: rtl/lcd_bus_rx.sv
// 8080 LCD bus receiver: decodes CASET/PASET/RAMWR traffic into RGB444 pixels with window cursor.
// Define LCD_BUS_RX_ERR_EN to build the sticky proto_err flag; otherwise proto_err is tied low.
module lcd_bus_rx
    import lcd_bus_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic       clk_100,
    input  logic       reset,
    input  logic [7:0] lcd_db,
    input  logic       lcd_wr,
    input  logic       lcd_d_c,
    input  logic       lcd_rd,
    input  logic       lcd_reset,
    output logic       pix_valid,
    output logic [8:0] pix_x,
    output logic [8:0] pix_y,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       frame_start,
    output logic       proto_err
);

    localparam logic [8:0] EC_RST = 9'(WIDTH - 1);
    localparam logic [8:0] EP_RST = 9'(HEIGHT - 1);
    localparam logic [9:0] X_LIM  = 10'(WIDTH);
    localparam logic [9:0] Y_LIM  = 10'(HEIGHT);

    logic       ev_s;
    logic [7:0] db_s;
    logic       dc_s;
    logic       rd_s;
    logic       panel_rst_n_s;

    rx_state_e  state_r;
    logic [8:0] sc_r, ec_r, sp_r, ep_r;
    logic [8:0] x_r, y_r;
    logic [6:0] hi_r;
    logic [8:0] x_nxt_s, y_nxt_s;
    logic       on_panel_s, accept_s, soft_rst_s;

    logic       pix_valid_r, frame_start_r;
    logic [8:0] pix_x_r, pix_y_r;
    logic [3:0] red_r, green_r, blue_r;

    lcd_bus_sync u_sync (
        .clk_100     (clk_100),
        .reset       (reset),
        .lcd_db      (lcd_db),
        .lcd_wr      (lcd_wr),
        .lcd_d_c     (lcd_d_c),
        .lcd_rd      (lcd_rd),
        .lcd_reset   (lcd_reset),
        .byte_ev     (ev_s),
        .byte_db     (db_s),
        .byte_dc     (dc_s),
        .byte_rd     (rd_s),
        .panel_rst_n (panel_rst_n_s)
    );

    assign accept_s   = ev_s & rd_s;
    assign soft_rst_s = ~panel_rst_n_s | (accept_s & ~dc_s & (db_s == CMD_SWRESET));
    assign on_panel_s = ({1'b0, x_r} < X_LIM) && ({1'b0, y_r} < Y_LIM);

    // Cursor advance; wrap only on equality, so an inverted window runs round the 9-bit range
    always_comb begin
        x_nxt_s = x_r + 9'd1;
        y_nxt_s = y_r;
        if (x_r == ec_r) begin
            x_nxt_s = sc_r;
            if (y_r == ep_r) begin
                y_nxt_s = sp_r;
            end else begin
                y_nxt_s = y_r + 9'd1;
            end
        end else begin
            x_nxt_s = x_r + 9'd1;
        end
    end

    // Command/parameter/pixel FSM with registered pixel outputs
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            sc_r          <= 9'd0;
            ec_r          <= EC_RST;
            sp_r          <= 9'd0;
            ep_r          <= EP_RST;
            x_r           <= 9'd0;
            y_r           <= 9'd0;
            hi_r          <= 7'd0;
            pix_valid_r   <= 1'b0;
            frame_start_r <= 1'b0;
            pix_x_r       <= 9'd0;
            pix_y_r       <= 9'd0;
            red_r         <= 4'd0;
            green_r       <= 4'd0;
            blue_r        <= 4'd0;
        end else if (soft_rst_s) begin
            state_r       <= ST_IDLE;
            sc_r          <= 9'd0;
            ec_r          <= EC_RST;
            sp_r          <= 9'd0;
            ep_r          <= EP_RST;
            x_r           <= 9'd0;
            y_r           <= 9'd0;
            hi_r          <= 7'd0;
            pix_valid_r   <= 1'b0;
            frame_start_r <= 1'b0;
            pix_x_r       <= 9'd0;
            pix_y_r       <= 9'd0;
            red_r         <= 4'd0;
            green_r       <= 4'd0;
            blue_r        <= 4'd0;
        end else begin
            pix_valid_r   <= 1'b0;
            frame_start_r <= 1'b0;
            if (accept_s && !dc_s) begin
                case (db_s)
                    CMD_CASET: state_r <= ST_CASET0;
                    CMD_PASET: state_r <= ST_PASET0;
                    CMD_RAMWR: begin
                        state_r       <= ST_RAMWR_HI;
                        x_r           <= sc_r;
                        y_r           <= sp_r;
                        frame_start_r <= 1'b1;
                    end
                    default:   state_r <= ST_IDLE;
                endcase
            end else if (accept_s) begin
                case (state_r)
                    ST_CASET0: begin sc_r[8]   <= db_s[0]; state_r <= ST_CASET1; end
                    ST_CASET1: begin sc_r[7:0] <= db_s;    state_r <= ST_CASET2; end
                    ST_CASET2: begin ec_r[8]   <= db_s[0]; state_r <= ST_CASET3; end
                    ST_CASET3: begin ec_r[7:0] <= db_s;    state_r <= ST_IDLE;   end
                    ST_PASET0: begin sp_r[8]   <= db_s[0]; state_r <= ST_PASET1; end
                    ST_PASET1: begin sp_r[7:0] <= db_s;    state_r <= ST_PASET2; end
                    ST_PASET2: begin ep_r[8]   <= db_s[0]; state_r <= ST_PASET3; end
                    ST_PASET3: begin ep_r[7:0] <= db_s;    state_r <= ST_IDLE;   end
                    ST_RAMWR_HI: begin
                        // Keep only the RGB565 bits that survive the reduction to RGB444
                        hi_r    <= {db_s[7:4], db_s[2:0]};
                        state_r <= ST_RAMWR_LO;
                    end
                    ST_RAMWR_LO: begin
                        pix_valid_r <= on_panel_s;
                        if (on_panel_s) begin
                            pix_x_r <= x_r;
                            pix_y_r <= y_r;
                            red_r   <= hi_r[6:3];
                            green_r <= {hi_r[2:0], db_s[7]};
                            blue_r  <= db_s[4:1];
                        end
                        x_r     <= x_nxt_s;
                        y_r     <= y_nxt_s;
                        state_r <= ST_RAMWR_HI;
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef LCD_BUS_RX_ERR_EN
    logic err_s;
    logic proto_err_r;

    // Read attempts, orphaned HI bytes and data bytes with no open command
    always_comb begin
        err_s = 1'b0;
        if (ev_s) begin
            if (!rd_s) begin
                err_s = 1'b1;
            end else if (!dc_s) begin
                err_s = (state_r == ST_RAMWR_LO);
            end else begin
                err_s = (state_r == ST_IDLE);
            end
        end else begin
            err_s = 1'b0;
        end
    end

    // Sticky error flag; soft reset deliberately leaves it alone
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            proto_err_r <= 1'b0;
        end else if (err_s) begin
            proto_err_r <= 1'b1;
        end
    end

    assign proto_err = proto_err_r;
`else
    assign proto_err = 1'b0;
`endif

    assign pix_valid   = pix_valid_r;
    assign pix_x       = pix_x_r;
    assign pix_y       = pix_y_r;
    assign red         = red_r;
    assign green       = green_r;
    assign blue        = blue_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Self-checking bench for lcd_bus_rx: directed vector table, corner sequences and a random run
// against a byte-level reference model. Honors LCD_BUS_RX_ERR_EN for proto_err expectations.
module tb_lcd_bus_rx;

    localparam int W = 320;
    localparam int H = 240;
`ifdef LCD_BUS_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk_100 = 1'b0;
    logic       reset;
    logic [7:0] lcd_db;
    logic       lcd_wr, lcd_d_c, lcd_rd, lcd_reset;
    logic       pix_valid, frame_start, proto_err;
    logic [8:0] pix_x, pix_y;
    logic [3:0] red, green, blue;

    int checks = 0;
    int errors = 0;

    lcd_bus_rx #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk_100     (clk_100),
        .reset       (reset),
        .lcd_db      (lcd_db),
        .lcd_wr      (lcd_wr),
        .lcd_d_c     (lcd_d_c),
        .lcd_rd      (lcd_rd),
        .lcd_reset   (lcd_reset),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_start (frame_start),
        .proto_err   (proto_err)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pix_t;

    typedef struct {
        bit         dc;
        logic [7:0] b;
        bit         v;
        pix_t       p;
        bit         fs;
    } vec_t;

    pix_t obs_q[$];
    pix_t exp_q[$];
    vec_t tbl[$];
    int   pv_cnt = 0;
    int   fs_cnt = 0;
    int   stab_err = 0;
    bit   stab_on = 1'b0;
    pix_t held;

    function automatic pix_t mk(input int x, input int y, input int r, input int g, input int b);
        pix_t p;
        p.x = 9'(x); p.y = 9'(y); p.r = 4'(r); p.g = 4'(g); p.b = 4'(b);
        return p;
    endfunction

    // Output monitor sampling on the falling edge
    always @(negedge clk_100) begin
        if (pix_valid) begin
            obs_q.push_back(mk(pix_x, pix_y, red, green, blue));
            pv_cnt <= pv_cnt + 1;
        end
        if (pix_valid || !stab_on) begin
            held <= mk(pix_x, pix_y, red, green, blue);
        end else if (mk(pix_x, pix_y, red, green, blue) != held) begin
            stab_err <= stab_err + 1;
        end
        if (frame_start) fs_cnt <= fs_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic hard_reset();
        reset = 1'b1; lcd_wr = 1'b0; lcd_rd = 1'b1; lcd_d_c = 1'b0; lcd_db = 8'd0; lcd_reset = 1'b1;
        repeat (3) @(negedge clk_100);
        reset = 1'b0;
        repeat (4) @(negedge clk_100);
    endtask

    task automatic send(input bit dc, input logic [7:0] b, input bit rd);
        @(negedge clk_100);
        lcd_db = b; lcd_d_c = dc; lcd_rd = rd;
        repeat (3) @(negedge clk_100);
        lcd_wr = 1'b1;
        repeat (4) @(negedge clk_100);
        lcd_wr = 1'b0;
        repeat (3) @(negedge clk_100);
        lcd_rd = 1'b1;
    endtask

    function automatic void add(input bit dc, input int b, input bit v, input int x, input int y,
                                input int r, input int g, input int bl, input bit fs);
        vec_t t;
        t.dc = dc; t.b = 8'(b); t.v = v; t.p = mk(x, y, r, g, bl); t.fs = fs;
        tbl.push_back(t);
    endfunction

    // Reference model: command/parameter/pixel semantics on plain integers
    int m_mode, m_idx, m_sc, m_ec, m_sp, m_ep, m_x, m_y, m_hi, m_fs;
    bit m_have_hi, m_err;

    function automatic void m_soft();
        m_mode = 0; m_idx = 0; m_sc = 0; m_ec = W - 1; m_sp = 0; m_ep = H - 1;
        m_x = 0; m_y = 0; m_have_hi = 1'b0;
    endfunction

    function automatic void m_byte(input bit dc, input int b, input bit rd);
        int pix, v, cur;
        if (!rd) begin
            m_err = 1'b1;
            return;
        end
        if (!dc) begin
            if (m_mode == 3 && m_have_hi) m_err = 1'b1;
            m_have_hi = 1'b0;
            m_idx = 0;
            case (b)
                8'h2A: m_mode = 1;
                8'h2B: m_mode = 2;
                8'h2C: begin m_mode = 3; m_x = m_sc; m_y = m_sp; m_fs++; end
                8'h01: m_soft();
                default: m_mode = 0;
            endcase
        end else if (m_mode == 0) begin
            m_err = 1'b1;
        end else if (m_mode == 3) begin
            if (!m_have_hi) begin
                m_hi = b; m_have_hi = 1'b1;
            end else begin
                pix = m_hi * 256 + b;
                m_have_hi = 1'b0;
                if (m_x < W && m_y < H)
                    exp_q.push_back(mk(m_x, m_y, pix >> 12, (pix >> 7) % 16, (pix >> 1) % 16));
                if (m_x == m_ec) begin
                    m_x = m_sc;
                    m_y = (m_y == m_ep) ? m_sp : (m_y + 1) % 512;
                end else begin
                    m_x = (m_x + 1) % 512;
                end
            end
        end else begin
            if (m_idx < 2) cur = (m_mode == 1) ? m_sc : m_sp;
            else           cur = (m_mode == 1) ? m_ec : m_ep;
            if (m_idx % 2 == 0) v = (b % 2) * 256 + cur % 256;
            else                v = (cur / 256) * 256 + b;
            if (m_idx < 2) begin if (m_mode == 1) m_sc = v; else m_sp = v; end
            else           begin if (m_mode == 1) m_ec = v; else m_ep = v; end
            m_idx++;
            if (m_idx == 4) m_mode = 0;
        end
    endfunction

    initial begin
        int pv0, fs0, lat, r, sel, b, n_cmp;
        bit dc, rd, got;

        // Directed vectors: default window, 2x2 window wrap, off-panel columns
        add(0, 8'h2C, 0, 0, 0, 0, 0, 0, 1);
        add(1, 8'hF8, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h00, 1, 0, 0, 15, 0, 0, 0);
        add(0, 8'h2A, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0); add(1, 8'h0A, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0); add(1, 8'h0B, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h2B, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0); add(1, 8'h05, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0); add(1, 8'h06, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h2C, 0, 0, 0, 0, 0, 0, 1);
        add(1, 8'h07, 0, 0, 0, 0, 0, 0, 0); add(1, 8'hE0, 1, 10, 5, 0, 15, 0, 0);
        add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0); add(1, 8'h1F, 1, 11, 5, 0, 0, 15, 0);
        add(1, 8'h12, 0, 0, 0, 0, 0, 0, 0); add(1, 8'h34, 1, 10, 6, 1, 4, 10, 0);
        add(1, 8'hFF, 0, 0, 0, 0, 0, 0, 0); add(1, 8'hFF, 1, 11, 6, 15, 15, 15, 0);
        add(1, 8'hA5, 0, 0, 0, 0, 0, 0, 0); add(1, 8'hC3, 1, 10, 5, 10, 11, 1, 0);
        add(0, 8'h2A, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h01, 0, 0, 0, 0, 0, 0, 0); add(1, 8'h3E, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h01, 0, 0, 0, 0, 0, 0, 0); add(1, 8'h41, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h2C, 0, 0, 0, 0, 0, 0, 1);
        add(1, 8'h80, 0, 0, 0, 0, 0, 0, 0); add(1, 8'h00, 1, 318, 5, 8, 0, 0, 0);
        add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0); add(1, 8'h80, 1, 319, 5, 0, 1, 0, 0);
        add(1, 8'h11, 0, 0, 0, 0, 0, 0, 0); add(1, 8'h11, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h22, 0, 0, 0, 0, 0, 0, 0); add(1, 8'h22, 0, 0, 0, 0, 0, 0, 0);

        hard_reset();
        check("reset_outputs", {pix_valid, pix_x, pix_y, red, green, blue, frame_start, proto_err}, 64'd0);

        stab_on = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            pv0 = pv_cnt; fs0 = fs_cnt;
            send(tbl[i].dc, tbl[i].b, 1'b1);
            check($sformatf("vec%0d_pix_count", i), 64'(pv_cnt - pv0), 64'(tbl[i].v));
            check($sformatf("vec%0d_frame_start", i), 64'(fs_cnt - fs0), 64'(tbl[i].fs));
            if (tbl[i].v && pv_cnt > pv0)
                check($sformatf("vec%0d_pixel", i), 64'(obs_q[$]), 64'(tbl[i].p));
        end
        stab_on = 1'b0;
        check("hold_stable", 64'(stab_err), 64'd0);

        // Interrupted pixel: HI byte orphaned by a command
        pv0 = pv_cnt;
        send(0, 8'h2C, 1); send(1, 8'h07, 1); send(0, 8'h2A, 1);
        check("interrupt_no_pixel", 64'(pv_cnt - pv0), 64'd0);
        check("interrupt_proto_err", 64'(proto_err), 64'(ERR_EN));
        send(1, 8'h00, 1); send(1, 8'h00, 1); send(1, 8'h01, 1); send(1, 8'h3F, 1);

        // Soft reset through lcd_reset after a custom window
        send(0, 8'h2A, 1); send(1, 8'h00, 1); send(1, 8'h0A, 1); send(1, 8'h00, 1); send(1, 8'h0B, 1);
        @(negedge clk_100); lcd_reset = 1'b0;
        repeat (3) @(negedge clk_100); lcd_reset = 1'b1;
        repeat (4) @(negedge clk_100);
        check("softreset_keeps_err", 64'(proto_err), 64'(ERR_EN));
        pv0 = pv_cnt;
        send(0, 8'h2C, 1); send(1, 8'h12, 1); send(1, 8'h34, 1);
        check("softreset_pix_count", 64'(pv_cnt - pv0), 64'd1);
        if (pv_cnt > pv0) check("softreset_pixel", 64'(obs_q[$]), 64'(mk(0, 0, 1, 4, 10)));

        // Read strobe active: byte ignored, cursor and HI slot untouched
        hard_reset();
        send(0, 8'h2C, 1); send(1, 8'h00, 1); send(1, 8'h00, 1);
        pv0 = pv_cnt;
        send(1, 8'h55, 0);
        check("read_no_pixel", 64'(pv_cnt - pv0), 64'd0);
        check("read_proto_err", 64'(proto_err), 64'(ERR_EN));
        send(1, 8'hFF, 1); send(1, 8'hFF, 1);
        check("read_pix_count", 64'(pv_cnt - pv0), 64'd1);
        if (pv_cnt > pv0) check("read_pixel", 64'(obs_q[$]), 64'(mk(1, 0, 15, 15, 15)));

        // Latency from first edge sampling lcd_wr high to pix_valid
        send(1, 8'h12, 1);
        @(negedge clk_100); lcd_db = 8'h34; lcd_d_c = 1'b1;
        repeat (3) @(negedge clk_100);
        lcd_wr = 1'b1; lat = 0; got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(posedge clk_100); lat++;
            @(negedge clk_100); if (pix_valid) got = 1'b1;
        end
        check("latency_edges", 64'(got ? lat : -1), 64'd4);
        lcd_wr = 1'b0;
        repeat (3) @(negedge clk_100);

        // Random traffic against the reference model
        hard_reset();
        m_soft(); m_err = 1'b0; m_fs = 0;
        obs_q.delete(); exp_q.delete(); fs0 = fs_cnt;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            rd = 1'b1;
            if (r < 4) begin
                rd = 1'b0; dc = 1'($urandom_range(0, 1)); b = $urandom_range(0, 255);
            end else if (r < 22) begin
                dc = 1'b0; sel = $urandom_range(0, 11);
                if (sel < 3)       b = 8'h2A;
                else if (sel < 6)  b = 8'h2B;
                else if (sel < 10) b = 8'h2C;
                else if (sel < 11) b = 8'h01;
                else               b = $urandom_range(0, 255);
            end else begin
                dc = 1'b1;
                if ((m_mode == 1 || m_mode == 2) && m_idx % 2 == 0) b = $urandom_range(0, 1);
                else b = $urandom_range(0, 255);
            end
            m_byte(dc, b, rd);
            send(dc, 8'(b), rd);
        end
        check("rand_pix_count", 64'(obs_q.size()), 64'(exp_q.size()));
        n_cmp = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++)
            check($sformatf("rand_pixel%0d", i), 64'(obs_q[i]), 64'(exp_q[i]));
        check("rand_frame_start", 64'(fs_cnt - fs0), 64'(m_fs));
        check("rand_proto_err", 64'(proto_err), 64'(ERR_EN & m_err));

        hard_reset();
        check("final_reset_clears", {pix_valid, pix_x, pix_y, red, green, blue, frame_start, proto_err}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
